interrupt_sequencer: RTL

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/leg_pkg.sv | 24 ++
 rtl/interrupt_sequencer_sync_chain.sv | 24 ++
 rtl/interrupt_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/leg_pkg.sv
// Shared encodings for the interrupt marker sequencer: FSM states, marker stage position, latched type.
// Pure type definitions; no logic, no latency, no flow control.
package leg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    POS_F = 2'd0,
    POS_D = 2'd1,
    POS_E = 2'd2,
    POS_M = 2'd3
  } pos_t;

  typedef enum logic {
    INT_IRQ = 1'b0,
    INT_FIQ = 1'b1
  } int_type_t;

endpackage

// File: rtl/interrupt_sequencer_sync_chain.sv
// Multi-flop synchronizer for one asynchronous level line; latency SYNC_STAGES cycles.
// No flow control: the line is sampled every cycle and the level is passed through.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic synced
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Walks an interrupt marker F->D->E->M through the pipeline, then pulses IRQ/FIQ once; SYNC_STAGES+5 cycles min.
// Marker holds on the stall of its current stage; flush, mask or request loss abandons the sequence.
module interrupt_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic IRQReq,
  input  logic FIQReq,
  input  logic IRQEnabled,
  input  logic FIQEnabled,
  input  logic StallF,
  input  logic StallD,
  input  logic StallE,
  input  logic StallM,
  input  logic FlushD,
  input  logic FlushE,
  input  logic FlushM,
  output logic PipelineClearF,
  output logic IRQ,
  output logic FIQ,
  output logic Busy
);

  import leg_pkg::*;

  logic       irq_sync;
  logic       fiq_sync;
  seq_state_t state, next_state;
  pos_t       pos, next_pos;
  int_type_t  int_type, next_type;
  logic       type_enabled;
  logic       type_pending;
  logic       marker_stall;
  logic       marker_flush;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    (IRQReq),
    .synced (irq_sync)
  );

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_fiq_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    (FIQReq),
    .synced (fiq_sync)
  );

  assign type_enabled = (int_type == INT_FIQ) ? FIQEnabled : IRQEnabled;
  assign type_pending = (int_type == INT_FIQ) ? fiq_sync : irq_sync;

  // Fetch has no flush input: a marker still in F can only be abandoned by mask or request loss.
  always_comb begin
    marker_stall = 1'b0;
    marker_flush = 1'b0;
    case (pos)
      POS_F: begin
        marker_stall = StallF;
      end
      POS_D: begin
        marker_stall = StallD;
        marker_flush = FlushD;
      end
      POS_E: begin
        marker_stall = StallE;
        marker_flush = FlushE;
      end
      POS_M: begin
        marker_stall = StallM;
        marker_flush = FlushM;
      end
      default: begin
        marker_stall = 1'b0;
        marker_flush = 1'b0;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    next_pos   = pos;
    next_type  = int_type;
    case (state)
      IDLE: begin
        if (fiq_sync && FIQEnabled) begin
          next_state = DRAIN;
          next_type  = INT_FIQ;
          next_pos   = POS_F;
        end else if (irq_sync && IRQEnabled) begin
          next_state = DRAIN;
          next_type  = INT_IRQ;
          next_pos   = POS_F;
        end
      end
      DRAIN: begin
        if (!type_enabled || !type_pending || marker_flush) begin
          next_state = IDLE;
        end else if (!marker_stall) begin
          if (pos == POS_M) begin
            next_state = FIRE;
          end else begin
            next_pos = pos_t'(pos + 2'd1);
          end
        end
      end
      FIRE: begin
        next_state = HOLD;
      end
      HOLD: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= POS_F;
      int_type <= INT_IRQ;
    end else begin
      state    <= next_state;
      pos      <= next_pos;
      int_type <= next_type;
    end
  end

  // Outputs decode registered state only, so raw request lines never reach them combinationally.
  assign PipelineClearF = (state == DRAIN) && (pos == POS_F);
  assign IRQ            = (state == FIRE) && (int_type == INT_IRQ);
  assign FIQ            = (state == FIRE) && (int_type == INT_FIQ);
  assign Busy           = (state != IDLE);

endmodule
